// File: rtl/register_file_banked_pkg.sv
// Shared types, sizing constants and bank-mapping helpers for the banked warp register file.
package register_file_banked_pkg;

  localparam int NumWarps        = 8;
  localparam int WarpWidth       = 8;
  localparam int RegIdxWidth     = 6;
  localparam int RegWidth        = 4;
  localparam int OperandsPerInst = 3;
  localparam int NumBanks        = 4;

  localparam int WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1;
  localparam int DataWidth     = RegWidth * WarpWidth;
  localparam int BankSelBits   = $clog2(NumBanks);
  localparam int BankIdxWidth  = (NumBanks > 1) ? BankSelBits : 1;
  localparam int BankAddrWidth = WidWidth + RegIdxWidth - BankSelBits;
  localparam int PortIdxWidth  = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

  // Bank count must be a power of two no larger than the register space.
  localparam bit NumBanksOk = (NumBanks > 0) && ((NumBanks & (NumBanks - 1)) == 0) &&
                              (NumBanks <= 2 ** RegIdxWidth);

  typedef logic [WidWidth-1:0]      wid_t;
  typedef logic [RegIdxWidth-1:0]   reg_idx_t;
  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [WarpWidth-1:0]     mask_t;
  typedef logic [BankIdxWidth-1:0]  bank_idx_t;
  typedef logic [BankAddrWidth-1:0] bank_addr_t;
  typedef logic [PortIdxWidth-1:0]  port_idx_t;

  function automatic bank_idx_t bank_index(input wid_t wid, input reg_idx_t reg_idx);
    reg_idx_t sum;
    sum = reg_idx + reg_idx_t'(wid);
    return (NumBanks == 1) ? bank_idx_t'(0) : bank_idx_t'(sum);
  endfunction

  // The bank already encodes the low register bits, so only the rest addresses the slice.
  function automatic bank_addr_t bank_addr(input wid_t wid, input reg_idx_t reg_idx);
    return {wid, reg_idx[RegIdxWidth-1:BankSelBits]};
  endfunction

endpackage

// File: rtl/register_file_bank.sv
// One storage bank: round-robin single read port over all operand ports plus a lane-masked write.
module register_file_bank
  import register_file_banked_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [OperandsPerInst-1:0] rd_req_i,
  input  bank_addr_t                 rd_addr_i [OperandsPerInst],
  output logic [OperandsPerInst-1:0] rd_gnt_o,
  output data_t                      rd_data_o,
  input  logic                       wr_en_i,
  input  bank_addr_t                 wr_addr_i,
  input  mask_t                      wr_mask_i,
  input  data_t                      wr_data_i
);

  localparam int Depth = 2 ** BankAddrWidth;

  data_t      mem_q [Depth];
  data_t      mem_d [Depth];
  port_idx_t  rr_q, rr_d;
  port_idx_t  gnt_idx;
  logic       gnt_found;
  bank_addr_t rd_addr;

  // First requester at or after the pointer wins, wrapping around the ports.
  always_comb begin
    rd_gnt_o  = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    rd_addr   = '0;
    for (int i = 0; i < OperandsPerInst; i++) begin
      if (!gnt_found && rd_req_i[(int'(rr_q) + i) % OperandsPerInst]) begin
        gnt_found = 1'b1;
        gnt_idx   = port_idx_t'((int'(rr_q) + i) % OperandsPerInst);
        rd_addr   = rd_addr_i[(int'(rr_q) + i) % OperandsPerInst];
        rd_gnt_o[(int'(rr_q) + i) % OperandsPerInst] = 1'b1;
      end
    end
    rr_d = rr_q;
    if (gnt_found) begin
      rr_d = (gnt_idx == port_idx_t'(OperandsPerInst - 1)) ? '0 : gnt_idx + port_idx_t'(1);
    end
  end

  assign rd_data_o = mem_q[rd_addr];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      for (int t = 0; t < WarpWidth; t++) begin
        if (wr_mask_i[t]) begin
          mem_d[wr_addr_i][t*RegWidth +: RegWidth] = wr_data_i[t*RegWidth +: RegWidth];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      for (int e = 0; e < Depth; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      rr_q  <= rr_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/register_file_banked.sv
// Banked warp register file: decodes operand reads to banks, steers grants and data back to
// ports with one-cycle latency, and applies lane-masked writebacks.
module register_file_banked
  import register_file_banked_pkg::*;
(
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [OperandsPerInst-1:0]                opc_read_req_valid_i,
  input  logic [OperandsPerInst-1:0][WidWidth-1:0]  opc_read_req_wid_i,
  input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] opc_read_req_reg_idx_i,
  output logic [OperandsPerInst-1:0]                opc_read_req_ready_o,
  output logic [OperandsPerInst-1:0]                opc_read_rsp_valid_o,
  output logic [OperandsPerInst-1:0][DataWidth-1:0] opc_read_rsp_data_o,
  input  logic                                      wb_valid_i,
  input  logic [WidWidth-1:0]                       wb_wid_i,
  input  logic [RegIdxWidth-1:0]                    wb_reg_idx_i,
  input  logic [WarpWidth-1:0]                      wb_act_mask_i,
  input  logic [DataWidth-1:0]                      wb_data_i,
  output logic                                      rf_wb_ready_o
);

  if (!NumBanksOk) begin : g_bank_check
    $error("NumBanks must be a power of two and no larger than the register space");
  end

  bank_idx_t                              port_bank [OperandsPerInst];
  bank_addr_t                             port_addr [OperandsPerInst];
  logic [NumBanks-1:0][OperandsPerInst-1:0] bank_req, bank_gnt;
  data_t                                  bank_rd_data [NumBanks];
  bank_idx_t                              wb_bank;
  bank_addr_t                             wb_addr;
  logic [OperandsPerInst-1:0]             ready;
  logic [OperandsPerInst-1:0]             rsp_valid_q, rsp_valid_d;
  logic [OperandsPerInst-1:0][DataWidth-1:0] rsp_data_q, rsp_data_d;

  // Requests are held off the banks during reset so no arbitration state moves.
  always_comb begin
    bank_req = '0;
    for (int p = 0; p < OperandsPerInst; p++) begin
      port_bank[p] = bank_index(opc_read_req_wid_i[p], opc_read_req_reg_idx_i[p]);
      port_addr[p] = bank_addr(opc_read_req_wid_i[p], opc_read_req_reg_idx_i[p]);
      if (opc_read_req_valid_i[p] && !rst_i) begin
        bank_req[port_bank[p]][p] = 1'b1;
      end
    end
  end

  assign wb_bank = bank_index(wb_wid_i, wb_reg_idx_i);
  assign wb_addr = bank_addr(wb_wid_i, wb_reg_idx_i);

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    register_file_bank u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_req_i  (bank_req[b]),
      .rd_addr_i (port_addr),
      .rd_gnt_o  (bank_gnt[b]),
      .rd_data_o (bank_rd_data[b]),
      .wr_en_i   (wb_valid_i && (wb_bank == bank_idx_t'(b))),
      .wr_addr_i (wb_addr),
      .wr_mask_i (wb_act_mask_i),
      .wr_data_i (wb_data_i)
    );
  end

  always_comb begin
    ready = '0;
    for (int b = 0; b < NumBanks; b++) begin
      ready = ready | bank_gnt[b];
    end
    for (int p = 0; p < OperandsPerInst; p++) begin
      rsp_valid_d[p] = ready[p];
      rsp_data_d[p]  = ready[p] ? bank_rd_data[port_bank[p]] : rsp_data_q[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Gating by reset drops a response that was in flight when reset arrived.
  assign opc_read_req_ready_o = ready;
  assign opc_read_rsp_valid_o = rst_i ? '0 : rsp_valid_q;
  assign opc_read_rsp_data_o  = rst_i ? '0 : rsp_data_q;
  assign rf_wb_ready_o        = 1'b1;

endmodule
